// File: rtl/sum3_share_arbiter.sv
// Shares one adder computing a+b+c among NREQ requesters, over two steps per operation.
// Build option SUM3ARB_RR_EN: round-robin arbitration if defined, fixed lowest-index priority if not.
module sum3_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*3*W-1:0]   req_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [W+1:0]          res_data,
    output logic [IDW-1:0]        res_id,
    output logic                  busy
);

    // Handshake: a word moves on either port only in a cycle where valid && ready.
    // req_ready is combinational and only asserted in IDLE; res_valid is held until res_ready.
    typedef enum logic [1:0] {IDLE, STEP0, STEP1, OUT} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   op_a, op_b, op_c;
    logic [IDW-1:0] gnt_id;
    logic [IDW-1:0] win_id;
    logic           win_found;
    logic           accept;
    logic [W:0]     temp;
    logic [W+1:0]   add_x, add_y, add_sum;

`ifdef SUM3ARB_RR_EN
    logic [IDW-1:0] ptr;
    logic [IDW:0]   rr_idx;

    // Search starts at ptr and wraps from NREQ-1 back to 0.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        rr_idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            rr_idx = {1'b0, ptr} + (IDW+1)'(i);
            if (rr_idx >= (IDW+1)'(NREQ))
                rr_idx = rr_idx - (IDW+1)'(NREQ);
            if (!win_found && req_valid[rr_idx[IDW-1:0]]) begin
                win_found = 1'b1;
                win_id    = rr_idx[IDW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (accept)
            ptr <= (win_id == IDW'(NREQ-1)) ? '0 : win_id + 1'b1;
    end
`else
    // Descending scan so the lowest requesting index is the last one written.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int i = NREQ-1; i >= 0; i--) begin
            if (req_valid[i]) begin
                win_found = 1'b1;
                win_id    = IDW'(i);
            end
        end
    end
`endif

    assign accept = (state == IDLE) && !rst && win_found;
    assign busy   = (state != IDLE);

    always_comb begin
        req_ready = '0;
        if (accept)
            req_ready[win_id] = 1'b1;
    end

    // The single shared adder: a+b in STEP0, temp+c in STEP1.
    always_comb begin
        add_x = {2'b00, op_a};
        add_y = {2'b00, op_b};
        if (state == STEP1) begin
            add_x = {1'b0, temp};
            add_y = {2'b00, op_c};
        end
    end

    assign add_sum = add_x + add_y;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = STEP0;
            STEP0:   state_nxt = STEP1;
            STEP1:   state_nxt = OUT;
            OUT:     if (res_valid && res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a      <= '0;
            op_b      <= '0;
            op_c      <= '0;
            gnt_id    <= '0;
            temp      <= '0;
            res_data  <= '0;
            res_id    <= '0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a   <= req_data[(3*W)*win_id + 2*W +: W];
                        op_b   <= req_data[(3*W)*win_id + W   +: W];
                        op_c   <= req_data[(3*W)*win_id       +: W];
                        gnt_id <= win_id;
                    end
                end
                STEP0: temp <= add_sum[W:0];
                STEP1: begin
                    res_data  <= add_sum;
                    res_id    <= gnt_id;
                    res_valid <= 1'b1;
                end
                OUT: begin
                    if (res_valid && res_ready)
                        res_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sum3_share_arbiter.sv
// Directed bench for sum3_share_arbiter; expectations follow SUM3ARB_RR_EN when defined.
module tb_sum3_share_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*3*W-1:0] req_data;
    logic                res_valid;
    logic                res_ready;
    logic [W+1:0]        res_data;
    logic [IDW-1:0]      res_id;
    logic                busy;

    int total = 0;
    int bad   = 0;
    int exp_sum [NREQ];
    int order   [$];

    sum3_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Caller is in an IDLE cycle with inputs set; walks one full operation ending back in IDLE.
    task automatic grant_cycle(input int g, input logic drop);
        #1;
        chk("grant", 32'(req_ready), 32'(1) << g);
        tick();
        if (drop) req_valid = '0;
        #1;
        chk("step0_busy", 32'(busy), 1);
        chk("step0_ready", 32'(req_ready), 0);
        chk("step0_resv", 32'(res_valid), 0);
        tick();
        #1;
        chk("step1_resv", 32'(res_valid), 0);
        chk("step1_ready", 32'(req_ready), 0);
        tick();
        #1;
        chk("out_resv", 32'(res_valid), 1);
        chk("out_data", 32'(res_data), 32'(exp_sum[g]));
        chk("out_id", 32'(res_id), 32'(g));
        chk("out_busy", 32'(busy), 1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_data = '0;
        req_data[0*24 +: 24] = 24'h010203;
        req_data[1*24 +: 24] = 24'h102030;
        req_data[2*24 +: 24] = 24'h0A0B0C;
        req_data[3*24 +: 24] = 24'hFFFFFF;
        exp_sum[0] = 6;
        exp_sum[1] = 96;
        exp_sum[2] = 33;
        exp_sum[3] = 765;

        // Reset state, with requests present while rst is high.
        rst = 1'b1;
        req_valid = '1;
        res_ready = 1'b1;
        tick();
        tick();
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_resv", 32'(res_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_data", 32'(res_data), 0);
        chk("rst_id", 32'(res_id), 0);
        req_valid = '0;
        rst = 1'b0;
        tick();

        // Single request from requester 2: 0x0A+0x0B+0x0C = 33.
        req_valid = 4'b0100;
        grant_cycle(2, 1'b1);
        #1;
        chk("single_idle_busy", 32'(busy), 0);
        chk("single_idle_resv", 32'(res_valid), 0);
        tick();

        // Maximum operands from requester 0.
        req_data[0*24 +: 24] = 24'hFFFFFF;
        exp_sum[0] = 765;
        req_valid = 4'b0001;
        grant_cycle(0, 1'b1);
        req_data[0*24 +: 24] = 24'h010203;
        exp_sum[0] = 6;

        // Contention from a fresh pointer.
        rst = 1'b1;
        tick();
        rst = 1'b0;
`ifdef SUM3ARB_RR_EN
        order = '{0, 1, 2, 3, 0};
`else
        order = '{0, 0, 0};
`endif
        req_valid = '1;
        foreach (order[k]) grant_cycle(order[k], 1'b0);
        req_valid = '0;
        #1;
        chk("contend_end_busy", 32'(busy), 0);
        tick();

        // Backpressure: result held for 5 cycles while requester 0 waits.
        req_valid = 4'b1000;
        res_ready = 1'b0;
        #1;
        chk("bp_grant", 32'(req_ready), 32'b1000);
        tick();
        req_valid = 4'b0001;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_resv", 32'(res_valid), 1);
            chk("bp_data", 32'(res_data), 765);
            chk("bp_id", 32'(res_id), 3);
            chk("bp_ready", 32'(req_ready), 0);
            tick();
        end
        res_ready = 1'b1;
        #1;
        chk("bp_last_resv", 32'(res_valid), 1);
        chk("bp_last_ready", 32'(req_ready), 0);
        tick();
        req_valid = '0;
        #1;
        chk("bp_done_resv", 32'(res_valid), 0);
        chk("bp_done_busy", 32'(busy), 0);
        tick();

`ifdef SUM3ARB_RR_EN
        // Wrap-around: grant 2 leaves pointer at 3, then 3 wins before 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 4'b0100;
        grant_cycle(2, 1'b1);
        req_valid = 4'b1001;
        grant_cycle(3, 1'b0);
        grant_cycle(0, 1'b1);
`endif

        // Reset during STEP1 discards the operation and clears the pointer.
        req_valid = 4'b0100;
        #1;
        chk("mid_grant", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        tick();
        rst = 1'b1;
        req_valid = 4'b1010;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 0);
        tick();
        rst = 1'b0;
        req_valid = '0;
        #1;
        chk("mid_after_resv", 32'(res_valid), 0);
        chk("mid_after_busy", 32'(busy), 0);
        chk("mid_after_data", 32'(res_data), 0);
        chk("mid_after_id", 32'(res_id), 0);
        tick();
        #1;
        chk("mid_idle_resv", 32'(res_valid), 0);
        tick();
        req_valid = 4'b1010;
        grant_cycle(1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
